// File: rtl/tournament_history_resolver.sv
// Tournament predictor back end: forms the final prediction, owns the speculative GHR,
// and tracks in-flight branches so it can emit training updates and repair history on resolve.
module tournament_history_resolver #(
    parameter  int HIST_BITS   = 12,
    parameter  int QUEUE_DEPTH = 4,
    localparam int CNT_BITS    = $clog2(QUEUE_DEPTH) + 1
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 pred_valid,
    output logic                 pred_ready,
    input  logic                 global_pred,
    input  logic                 local_pred,
    input  logic                 choice_prediction,
    output logic                 final_taken,
    output logic [HIST_BITS-1:0] global_history,
    input  logic                 resolve_valid,
    input  logic                 actually_taken,
    output logic                 upd_valid,
    output logic [HIST_BITS-1:0] upd_history,
    output logic                 upd_choice_valid,
    output logic                 upd_choose_global,
    output logic                 mispredict,
    output logic [CNT_BITS-1:0]  queue_count
);

    localparam int                PTR_W   = $clog2(QUEUE_DEPTH);
    localparam logic [CNT_BITS-1:0] DEPTH_C = CNT_BITS'(QUEUE_DEPTH);

    typedef struct packed {
        logic [HIST_BITS-1:0] hist;
        logic                 gp;
        logic                 lp;
        logic                 fin;
    } entry_t;

    entry_t               entry_q [QUEUE_DEPTH];
    logic [PTR_W-1:0]     head_q, head_d;
    logic [PTR_W-1:0]     tail_q, tail_d;
    logic [CNT_BITS-1:0]  count_q, count_d;
    logic [HIST_BITS-1:0] ghr_q, ghr_d;

    logic                 upd_valid_q, upd_valid_d;
    logic [HIST_BITS-1:0] upd_history_q, upd_history_d;
    logic                 upd_cv_q, upd_cv_d;
    logic                 upd_cg_q, upd_cg_d;
    logic                 misp_q, misp_d;

    entry_t head_e;
    logic   resolve_go;
    logic   head_wrong;
    logic   accept;

    always_comb begin
        final_taken = choice_prediction ? global_pred : local_pred;
        head_e      = entry_q[head_q];
        resolve_go  = resolve_valid && (count_q != '0);
        head_wrong  = resolve_go && (head_e.fin != actually_taken);
        // A full queue refuses new work even if the head pops this cycle.
        pred_ready  = (count_q < DEPTH_C) && !head_wrong;
        accept      = pred_valid && pred_ready;

        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        ghr_d   = ghr_q;

        if (head_wrong) begin
            head_d  = head_q + 1'b1;
            tail_d  = head_q + 1'b1;
            count_d = '0;
            ghr_d   = {head_e.hist[HIST_BITS-2:0], actually_taken};
        end else begin
            if (accept) begin
                tail_d = tail_q + 1'b1;
                ghr_d  = {ghr_q[HIST_BITS-2:0], final_taken};
            end
            if (resolve_go) begin
                head_d = head_q + 1'b1;
            end
            case ({accept, resolve_go})
                2'b10:   count_d = count_q + 1'b1;
                2'b01:   count_d = count_q - 1'b1;
                default: count_d = count_q;
            endcase
        end

        upd_valid_d   = resolve_go;
        upd_history_d = resolve_go ? head_e.hist : '0;
        upd_cv_d      = resolve_go && (head_e.gp != head_e.lp);
        upd_cg_d      = resolve_go && (head_e.gp == actually_taken);
        misp_d        = head_wrong;
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            head_q        <= '0;
            tail_q        <= '0;
            count_q       <= '0;
            ghr_q         <= '0;
            upd_valid_q   <= 1'b0;
            upd_history_q <= '0;
            upd_cv_q      <= 1'b0;
            upd_cg_q      <= 1'b0;
            misp_q        <= 1'b0;
        end else begin
            head_q        <= head_d;
            tail_q        <= tail_d;
            count_q       <= count_d;
            ghr_q         <= ghr_d;
            upd_valid_q   <= upd_valid_d;
            upd_history_q <= upd_history_d;
            upd_cv_q      <= upd_cv_d;
            upd_cg_q      <= upd_cg_d;
            misp_q        <= misp_d;
        end
    end

    // Queue storage carries no reset; entries are only read while counted as valid.
    always_ff @(posedge clock) begin
        if (accept) begin
            entry_q[tail_q] <= '{hist: ghr_q, gp: global_pred, lp: local_pred, fin: final_taken};
        end
    end

    assign global_history    = ghr_q;
    assign queue_count       = count_q;
    assign upd_valid         = upd_valid_q;
    assign upd_history       = upd_history_q;
    assign upd_choice_valid  = upd_cv_q;
    assign upd_choose_global = upd_cg_q;
    assign mispredict        = misp_q;

endmodule

// File: tb/tb_tournament_history_resolver.sv
// Directed table-driven bench for tournament_history_resolver.
module tb_tournament_history_resolver;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic        pred_valid = 1'b0, global_pred = 1'b0, local_pred = 1'b0, choice_prediction = 1'b0;
    logic        resolve_valid = 1'b0, actually_taken = 1'b0;
    logic        pred_ready, final_taken, upd_valid, upd_choice_valid, upd_choose_global, mispredict;
    logic [11:0] global_history, upd_history;
    logic [2:0]  queue_count;

    int total = 0;
    int passed = 0;

    tournament_history_resolver #(.HIST_BITS(12), .QUEUE_DEPTH(4)) dut (
        .clock(clock), .reset(reset),
        .pred_valid(pred_valid), .pred_ready(pred_ready),
        .global_pred(global_pred), .local_pred(local_pred),
        .choice_prediction(choice_prediction), .final_taken(final_taken),
        .global_history(global_history),
        .resolve_valid(resolve_valid), .actually_taken(actually_taken),
        .upd_valid(upd_valid), .upd_history(upd_history),
        .upd_choice_valid(upd_choice_valid), .upd_choose_global(upd_choose_global),
        .mispredict(mispredict), .queue_count(queue_count)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic        pv, c, g, l, rv, at;
        logic        fin, rdy;
        logic [11:0] ghr;
        logic [2:0]  cnt;
        logic        uv;
        logic [11:0] uh;
        logic        cv, cg, mp;
    } vec_t;

    function automatic vec_t v(input logic pv, c, g, l, rv, at, fin, rdy,
                               input logic [11:0] ghr, input logic [2:0] cnt,
                               input logic uv, input logic [11:0] uh,
                               input logic cv, cg, mp);
        vec_t r;
        r.pv = pv; r.c = c; r.g = g; r.l = l; r.rv = rv; r.at = at;
        r.fin = fin; r.rdy = rdy; r.ghr = ghr; r.cnt = cnt;
        r.uv = uv; r.uh = uh; r.cv = cv; r.cg = cg; r.mp = mp;
        return r;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    endtask

    task automatic apply(input vec_t t, input int idx);
        @(negedge clock);
        pred_valid = t.pv; choice_prediction = t.c; global_pred = t.g; local_pred = t.l;
        resolve_valid = t.rv; actually_taken = t.at;
        #1;
        chk($sformatf("v%0d final_taken", idx), {31'b0, final_taken}, {31'b0, t.fin});
        chk($sformatf("v%0d pred_ready", idx), {31'b0, pred_ready}, {31'b0, t.rdy});
        @(posedge clock);
        #1;
        chk($sformatf("v%0d ghr", idx), {20'b0, global_history}, {20'b0, t.ghr});
        chk($sformatf("v%0d count", idx), {29'b0, queue_count}, {29'b0, t.cnt});
        chk($sformatf("v%0d upd_valid", idx), {31'b0, upd_valid}, {31'b0, t.uv});
        chk($sformatf("v%0d upd_history", idx), {20'b0, upd_history}, {20'b0, t.uh});
        chk($sformatf("v%0d upd_choice_valid", idx), {31'b0, upd_choice_valid}, {31'b0, t.cv});
        chk($sformatf("v%0d upd_choose_global", idx), {31'b0, upd_choose_global}, {31'b0, t.cg});
        chk($sformatf("v%0d mispredict", idx), {31'b0, mispredict}, {31'b0, t.mp});
    endtask

    task automatic idle_inputs();
        pred_valid = 0; choice_prediction = 0; global_pred = 0; local_pred = 0;
        resolve_valid = 0; actually_taken = 0;
    endtask

    task automatic do_reset(input string tag);
        @(negedge clock);
        idle_inputs();
        reset = 0;
        repeat (2) @(negedge clock);
        reset = 1;
        #1;
        chk({tag, " rst ghr"}, {20'b0, global_history}, 32'h0);
        chk({tag, " rst count"}, {29'b0, queue_count}, 32'h0);
        chk({tag, " rst pred_ready"}, {31'b0, pred_ready}, 32'h1);
        chk({tag, " rst upd_valid"}, {31'b0, upd_valid}, 32'h0);
        chk({tag, " rst mispredict"}, {31'b0, mispredict}, 32'h0);
    endtask

    vec_t tbl [14];

    initial begin
        //            pv c g l rv at fin rdy ghr     cnt uv uh      cv cg mp
        tbl[0]  = v(1, 1,1,0, 0,0, 1, 1, 12'h001, 1, 0, 12'h000, 0, 0, 0);
        tbl[1]  = v(0, 0,0,0, 1,1, 0, 1, 12'h001, 0, 1, 12'h000, 1, 1, 0);
        tbl[2]  = v(0, 0,0,0, 1,0, 0, 1, 12'h001, 0, 0, 12'h000, 0, 0, 0);
        tbl[3]  = v(1, 0,0,1, 0,0, 1, 1, 12'h003, 1, 0, 12'h000, 0, 0, 0);
        tbl[4]  = v(1, 0,0,1, 0,0, 1, 1, 12'h007, 2, 0, 12'h000, 0, 0, 0);
        tbl[5]  = v(1, 0,0,1, 0,0, 1, 1, 12'h00F, 3, 0, 12'h000, 0, 0, 0);
        tbl[6]  = v(1, 0,0,1, 0,0, 1, 1, 12'h01F, 4, 0, 12'h000, 0, 0, 0);
        tbl[7]  = v(1, 0,0,1, 0,0, 1, 0, 12'h01F, 4, 0, 12'h000, 0, 0, 0);
        tbl[8]  = v(1, 0,0,1, 1,1, 1, 0, 12'h01F, 3, 1, 12'h001, 1, 0, 0);
        tbl[9]  = v(1, 1,0,0, 1,1, 0, 1, 12'h03E, 3, 1, 12'h003, 1, 0, 0);
        tbl[10] = v(1, 1,1,1, 1,0, 1, 0, 12'h00E, 0, 1, 12'h007, 1, 1, 1);
        tbl[11] = v(0, 0,0,0, 0,0, 0, 1, 12'h00E, 0, 0, 12'h000, 0, 0, 0);
        tbl[12] = v(1, 0,1,1, 0,0, 1, 1, 12'h01D, 1, 0, 12'h000, 0, 0, 0);
        tbl[13] = v(0, 0,0,0, 1,0, 0, 0, 12'h01C, 0, 1, 12'h00E, 0, 0, 1);

        do_reset("r1");
        for (int i = 0; i < 14; i++) apply(tbl[i], i);

        // Three accepts then a correct resolve followed by a mispredicting one.
        do_reset("r2");
        apply(v(1, 1,1,1, 0,0, 1, 1, 12'h001, 1, 0, 12'h000, 0, 0, 0), 100);
        apply(v(1, 1,1,1, 0,0, 1, 1, 12'h003, 2, 0, 12'h000, 0, 0, 0), 101);
        apply(v(1, 1,1,1, 0,0, 1, 1, 12'h007, 3, 0, 12'h000, 0, 0, 0), 102);
        apply(v(0, 0,0,0, 1,1, 0, 1, 12'h007, 2, 1, 12'h000, 0, 1, 0), 103);
        apply(v(0, 0,0,0, 1,0, 0, 0, 12'h002, 0, 1, 12'h001, 0, 0, 1), 104);
        apply(v(0, 0,0,0, 0,0, 0, 1, 12'h002, 0, 0, 12'h000, 0, 0, 0), 105);

        // Asynchronous reset asserted between edges with two entries in flight.
        apply(v(1, 0,0,1, 0,0, 1, 1, 12'h005, 1, 0, 12'h000, 0, 0, 0), 200);
        apply(v(1, 0,0,1, 1,1, 1, 1, 12'h00B, 1, 1, 12'h002, 1, 0, 0), 201);
        apply(v(1, 0,0,1, 0,0, 1, 1, 12'h017, 2, 0, 12'h000, 0, 0, 0), 202);
        @(negedge clock);
        idle_inputs();
        #2;
        reset = 0;
        #1;
        chk("async ghr", {20'b0, global_history}, 32'h0);
        chk("async count", {29'b0, queue_count}, 32'h0);
        chk("async upd_valid", {31'b0, upd_valid}, 32'h0);
        @(negedge clock);
        reset = 1;
        #1;
        chk("async pred_ready", {31'b0, pred_ready}, 32'h1);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
